// File: rtl/rx_nrzi_unstuff_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_nrzi_unstuff_if
//  Description : Bundle between the USB receive line sampler (timer / edge
//                detector side) and the NRZI decode / bit-unstuff stage.
//                  d_plus_sync  - synchronized D+ level (idle/J = 1)
//                  shift_enable - one-cycle bit-centre strobe from the timer
//                  rcving       - packet-in-progress flag from the RCU
//                  rx_byte      - last completed decoded byte
//                  byte_valid   - one-cycle pulse, rx_byte just updated
//                  stuff_err    - sticky stuff-bit violation flag
//                  align_err    - one-cycle pulse, packet ended mid-byte
//                Modport slave is the decoder, master is the surrounding logic.
//  Revision    : 1.0  initial release
// ============================================================================
interface rx_nrzi_unstuff_if #(
    parameter int DATA_W = 8
);
    logic              d_plus_sync;
    logic              shift_enable;
    logic              rcving;
    logic [DATA_W-1:0] rx_byte;
    logic              byte_valid;
    logic              stuff_err;
    logic              align_err;

    modport slave (
        input  d_plus_sync,
        input  shift_enable,
        input  rcving,
        output rx_byte,
        output byte_valid,
        output stuff_err,
        output align_err
    );

    modport master (
        output d_plus_sync,
        output shift_enable,
        output rcving,
        input  rx_byte,
        input  byte_valid,
        input  stuff_err,
        input  align_err
    );
endinterface
`default_nettype wire

// File: rtl/rx_nrzi_unstuff.sv
`default_nettype none
// ============================================================================
//  Module      : rx_nrzi_unstuff
//  Description : USB receive stage. On each shift_enable strobe while a
//                packet is in progress it NRZI-decodes d_plus_sync, drops
//                stuff bits after STUFF_LEN consecutive 1s, assembles
//                LSB-first words of DATA_W bits and pulses byte_valid for
//                each completed word.
//  Ports       : clk, rst (sync, active-high), bus (rx_nrzi_unstuff_if.slave)
//  Option      : RX_STUFF_CHECK_EN - when defined, a stuff bit that decodes
//                as 1 raises stuff_err and parks the FSM in ERR until rcving
//                drops; when undefined stuff bits are dropped unchecked and
//                stuff_err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module rx_nrzi_unstuff #(
    parameter int DATA_W    = 8,
    parameter int STUFF_LEN = 6
) (
    input  wire logic           clk,
    input  wire logic           rst,
    rx_nrzi_unstuff_if.slave    bus
);
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int ONES_W = $clog2(STUFF_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t            r_state,     w_state_nxt;
    logic              r_prev_line, w_prev_nxt;
    logic [ONES_W-1:0] r_ones,      w_ones_nxt;
    logic [CNT_W-1:0]  r_bit_cnt,   w_bit_nxt;
    logic [DATA_W-1:0] r_shreg,     w_shreg_nxt;
    logic [DATA_W-1:0] r_rx_byte,   w_byte_nxt;
    logic              r_valid,     w_valid_nxt;
    logic              r_align,     w_align_nxt;

    logic              w_dec_bit;
    logic [DATA_W-1:0] w_shreg_shift;

    // NRZI: no transition means a 1
    assign w_dec_bit     = (bus.d_plus_sync == r_prev_line);
    assign w_shreg_shift = {w_dec_bit, r_shreg[DATA_W-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev_line;
        w_ones_nxt  = r_ones;
        w_bit_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        w_byte_nxt  = r_rx_byte;
        w_valid_nxt = 1'b0;
        w_align_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.rcving) begin
                    w_state_nxt = ST_RECV;
                end
            end

            ST_RECV: begin
                // rcving dropping wins over a coincident strobe
                if (!bus.rcving) begin
                    w_state_nxt = ST_IDLE;
                    w_prev_nxt  = 1'b1;
                    w_ones_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_shreg_nxt = '0;
                    w_align_nxt = (r_bit_cnt != '0);
                end else if (bus.shift_enable) begin
                    w_prev_nxt = bus.d_plus_sync;
                    if (r_ones == ONES_W'(STUFF_LEN)) begin
                        // stuff bit: consumed for line history only
                        w_ones_nxt = '0;
`ifdef RX_STUFF_CHECK_EN
                        if (w_dec_bit) begin
                            w_state_nxt = ST_ERR;
                        end
`endif
                    end else begin
                        w_shreg_nxt = w_shreg_shift;
                        w_ones_nxt  = w_dec_bit ? (r_ones + 1'b1) : '0;
                        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                            w_bit_nxt   = '0;
                            w_byte_nxt  = w_shreg_shift;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end
                end
            end

            ST_ERR: begin
                if (!bus.rcving) begin
                    w_state_nxt = ST_IDLE;
                    w_prev_nxt  = 1'b1;
                    w_ones_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_shreg_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prev_line <= 1'b1;
            r_ones      <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_rx_byte   <= '0;
            r_valid     <= 1'b0;
            r_align     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_line <= w_prev_nxt;
            r_ones      <= w_ones_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shreg     <= w_shreg_nxt;
            r_rx_byte   <= w_byte_nxt;
            r_valid     <= w_valid_nxt;
            r_align     <= w_align_nxt;
        end
    end

    assign bus.rx_byte    = r_rx_byte;
    assign bus.byte_valid = r_valid;
    assign bus.align_err  = r_align;

    // ERR is only ever entered through a violation and left on IDLE entry,
    // so the sticky flag is exactly "FSM is in ERR".
`ifdef RX_STUFF_CHECK_EN
    assign bus.stuff_err = (r_state == ST_ERR);
`else
    assign bus.stuff_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/rx_nrzi_unstuff.md
Name: rx_nrzi_unstuff

Overview:
USB receive-path stage that sits directly downstream of the timer and edge detector. It samples the synchronized d_plus line on each timer shift_enable strobe, NRZI-decodes the bit and removes USB bit stuffing. It assembles LSB-first bytes and hands each completed byte to the receiver control unit with a one-cycle valid pulse. It replaces the timer's raw byte_received count, which cannot account for stuffed bits.

Parameters:
DATA_W, 8, width of assembled word in bits
STUFF_LEN, 6, number of consecutive decoded 1s after which the next bit is a stuff bit

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
d_plus_sync  input  1  synchronized D+ level (idle/J = 1)
shift_enable  input  1  one-cycle strobe from timer at bit centre
rcving  input  1  packet-in-progress flag from RCU
rx_byte  output  DATA_W  last completed decoded byte
byte_valid  output  1  one-cycle pulse: rx_byte just updated
stuff_err  output  1  sticky: stuff-bit violation in current packet
align_err  output  1  one-cycle pulse: packet ended mid-byte

Behaviour:
- Reset (rst=1 at a clk edge):
  - rx_byte=0, byte_valid=0, stuff_err=0, align_err=0.
  - FSM=IDLE, prev_line=1, ones_cnt=0, bit_cnt=0, shift register=0.
- FSM states: IDLE, RECV, ERR.
  - IDLE -> RECV when rcving=1.
  - RECV -> IDLE when rcving=0.
  - RECV -> ERR on a stuff violation.
  - ERR -> IDLE when rcving=0.
- A shift is processed only when rcving=1 and shift_enable=1 in the same cycle, in state RECV.
  - If rcving falls in the same cycle as a strobe, rcving takes priority and the shift is ignored.
- NRZI decode: decoded bit = 1 if d_plus_sync == prev_line, else 0. Every processed shift, including stuff bits, updates prev_line <= d_plus_sync.
- Stuff handling:
  - ones_cnt counts consecutive decoded 1s (saturating range 0..STUFF_LEN).
  - When ones_cnt==STUFF_LEN, the current bit is a stuff bit. It is discarded (no shift, bit_cnt unchanged) and ones_cnt <= 0.
  - If that stuff bit decodes as 1, it is a violation (see Optional Feature).
  - For a normal bit: decoded 1 -> ones_cnt+1; decoded 0 -> ones_cnt <= 0.
- Assembly:
  - Normal bit: shreg <= {bit, shreg[DATA_W-1:1]} (LSB first), bit_cnt <= bit_cnt+1.
  - When the shifted bit is the DATA_W-th bit: rx_byte <= new shreg value and byte_valid=1 for exactly one cycle (the cycle after the strobe), bit_cnt wraps to 0.
- Latency: rx_byte and byte_valid update on the edge that samples the final strobe, i.e. visible one cycle after that strobe.
- Leaving RECV or ERR (rcving=0):
  - prev_line <= 1; ones_cnt, bit_cnt and shreg cleared.
  - stuff_err cleared on the IDLE entry edge.
  - rx_byte holds its last value.
  - If leaving RECV with bit_cnt != 0: align_err pulses for one cycle and no byte_valid is issued.
- ERR: all strobes are ignored, no byte_valid, stuff_err held at 1.
- rst mid-packet: all state is discarded; the next packet starts clean from IDLE with prev_line=1.

Optional Feature:
Macro RX_STUFF_CHECK_EN.
- Defined: a stuff bit decoding as 1 sets stuff_err=1 (registered, visible the cycle after the strobe) and moves the FSM to ERR.
- Undefined: the stuff bit is discarded regardless of value, the ERR state is unreachable, and stuff_err is tied to 0.

Test Plan:
- SYNC byte: rcving=1, d_plus_sync at 8 strobes = 0,1,0,1,0,1,0,0 -> rx_byte=0x80, byte_valid high one cycle after the 8th strobe, stuff_err=0.
- Stuffed 0xFF: levels 1,1,1,1,1,1 (six 1s), then 0 (stuff), then 0,0 -> no valid at strobe 8; rx_byte=0xFF and byte_valid after the 9th strobe; the next byte decodes relative to prev_line=0.
- Stuff violation (RX_STUFF_CHECK_EN): seven consecutive 1 levels from idle -> stuff_err=1 after the 7th strobe; further strobes produce no byte_valid; rcving=0 -> stuff_err=0 next cycle.
- Truncated packet: 3 strobes with levels 0,1,0, then rcving=0 -> align_err pulses once, no byte_valid, rx_byte keeps its previous value.
- Strobe and rcving fall together after 7 bits -> shift ignored, align_err=1, no byte_valid.
- Reset mid-byte: rst after 4 strobes, then a new packet with the SYNC pattern -> rx_byte=0x80 with no residue from the earlier bits.
